// File: rtl/alsu_result_buffer_if.sv
// Sample and read-handshake bundle between the ALSU, the result buffer and its consumer.
//   in_valid, out, leds : ALSU sample (producer -> buffer)
//   rd_ready            : consumer ready (consumer -> buffer)
//   rd_valid, rd_data   : show-ahead head of FIFO (buffer -> consumer)
// master: producer/consumer side. slave: the buffer.
interface alsu_result_buffer_if;
  logic              in_valid;
  logic signed [5:0] out;
  logic [15:0]       leds;
  logic              rd_ready;
  logic              rd_valid;
  logic signed [5:0] rd_data;

  modport master (
    output in_valid,
    output out,
    output leds,
    output rd_ready,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  in_valid,
    input  out,
    input  leds,
    input  rd_ready,
    output rd_valid,
    output rd_data
  );
endinterface

// File: rtl/alsu_result_buffer.sv
// ALSU result buffer: classifies each valid ALSU sample as good (leds == 0) or error,
// counts error samples, stores good samples in a show-ahead FIFO and keeps a saturating
// signed running sum of every stored sample. A flush request drains the FIFO while
// blocking writes.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : sample input and read handshake (slave side)
//   flush       : single-cycle drain request
//   acc_clr     : synchronous accumulator clear
//   count       : FIFO occupancy
//   acc         : saturating signed sum of stored samples
//   err_cnt     : saturating count of error samples
//   drop_cnt    : saturating count of good samples that were not stored
//   flush_busy  : high while draining
module alsu_result_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ACC_W = 10,
  parameter int unsigned CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  alsu_result_buffer_if.slave        bus,
  input  logic                       flush,
  input  logic                       acc_clr,
  output logic [$clog2(DEPTH):0]     count,
  output logic signed [ACC_W-1:0]    acc,
  output logic [CNT_W-1:0]           err_cnt,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       flush_busy
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned OccW  = PtrW + 1;
  localparam int unsigned DataW = 6;
  localparam logic [OccW-1:0] DepthC = OccW'(DEPTH);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e                  state_q, state_d;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]         count_q, count_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]        drop_cnt_q, drop_cnt_d;
  logic                    flush_busy_q, flush_busy_d;

  logic signed [DataW-1:0] mem_q [DEPTH];

  logic             good, err, push, pop;
  logic [ACC_W:0]   sum;

  always_comb begin
    good = bus.in_valid && (bus.leds == '0);
    err  = bus.in_valid && (bus.leds != '0);
    // Occupancy is the pre-edge value: a same-cycle pop never frees a slot for the push.
    push = good && (state_q == StRun) && (count_q < DepthC);
    pop  = (count_q != '0) && bus.rd_ready;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    acc_d        = acc_q;
    err_cnt_d    = err_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    state_d      = state_q;
    flush_busy_d = flush_busy_q;

    // One guard bit catches signed overflow of acc + out.
    sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W + 1 - DataW){bus.out[DataW-1]}}, bus.out};

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

    if (push && !pop) begin
      count_d = count_q + OccW'(1);
    end else if (pop && !push) begin
      count_d = count_q - OccW'(1);
    end

    if (acc_clr) begin
      acc_d = '0;
    end else if (push) begin
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        acc_d = sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end

    if (err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
    if (good && !push && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);

    unique case (state_q)
      StRun: begin
        if (flush) state_d = StFlush;
      end
      StFlush: begin
        if (count_d == '0) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
    flush_busy_d = (state_d == StFlush);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      acc_q        <= '0;
      err_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      flush_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      acc_q        <= acc_d;
      err_cnt_q    <= err_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      flush_busy_q <= flush_busy_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted as occupied.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= bus.out;
  end

  always_comb begin
    bus.rd_valid = (count_q != '0);
    bus.rd_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    count        = count_q;
    acc          = acc_q;
    err_cnt      = err_cnt_q;
    drop_cnt     = drop_cnt_q;
    flush_busy   = flush_busy_q;
  end

endmodule

// File: tb/tb_alsu_result_buffer.sv
// Directed bench for alsu_result_buffer with default parameters (DEPTH 8, ACC_W 10, CNT_W 8).
module tb_alsu_result_buffer;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              acc_clr;
  logic [3:0]        count;
  logic signed [9:0] acc;
  logic [7:0]        err_cnt;
  logic [7:0]        drop_cnt;
  logic              flush_busy;

  int checks = 0;
  int errors = 0;

  alsu_result_buffer_if bus ();

  alsu_result_buffer #(
    .DEPTH (8),
    .ACC_W (10),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .flush      (flush),
    .acc_clr    (acc_clr),
    .count      (count),
    .acc        (acc),
    .err_cnt    (err_cnt),
    .drop_cnt   (drop_cnt),
    .flush_busy (flush_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.out      = '0;
    bus.leds     = '0;
    bus.rd_ready = 1'b0;
    flush        = 1'b0;
    acc_clr      = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic push_good(input int v);
    bus.in_valid = 1'b1;
    bus.leds     = '0;
    bus.out      = 6'(v);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_count", count, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_acc", acc, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_flush_busy", flush_busy, 0);

    // Three good samples, then read them back in order
    push_good(5);
    push_good(-3);
    push_good(31);
    check("t1_count", count, 3);
    check("t1_rd_valid", bus.rd_valid, 1);
    check("t1_rd_data", bus.rd_data, 5);
    check("t1_acc", acc, 33);
    bus.rd_ready = 1'b1;
    check("t1_rd0", bus.rd_data, 5);
    tick();
    check("t1_rd1", bus.rd_data, -3);
    tick();
    check("t1_rd2", bus.rd_data, 31);
    tick();
    check("t1_empty_valid", bus.rd_valid, 0);
    check("t1_empty_count", count, 0);
    check("t1_empty_data", bus.rd_data, 0);
    // rd_ready while empty has no effect
    tick();
    check("t1_empty_pop", count, 0);
    bus.rd_ready = 1'b0;

    // Fill past capacity
    do_reset();
    for (int i = 0; i < 9; i++) push_good(1);
    check("fill_count", count, 8);
    check("fill_drop", drop_cnt, 1);
    check("fill_acc", acc, 8);

    // Full with simultaneous pop: the pop does not make room for the sample
    bus.rd_ready = 1'b1;
    push_good(2);
    bus.rd_ready = 1'b0;
    check("full_pop_count", count, 7);
    check("full_pop_drop", drop_cnt, 2);
    check("full_pop_acc", acc, 8);

    // in_valid low is ignored even with LEDs lit
    bus.in_valid = 1'b0;
    bus.leds     = 16'hFFFF;
    bus.out      = 6'd7;
    tick();
    check("idle_err", err_cnt, 0);

    // Error samples
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("err_cnt3", err_cnt, 3);
    check("err_count", count, 7);
    check("err_acc", acc, 8);
    for (int i = 0; i < 297; i++) tick();
    check("err_sat", err_cnt, 255);
    bus.in_valid = 1'b0;
    bus.leds     = '0;

    // Positive saturation with continuous draining
    do_reset();
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 100; i++) push_good(31);
    check("sat_count", count, 1);
    tick();
    check("sat_drain", count, 0);
    check("sat_acc_pos", acc, 511);
    check("sat_drop", drop_cnt, 0);
    bus.rd_ready = 1'b0;

    // acc_clr wins over the add but the sample is still stored
    acc_clr = 1'b1;
    push_good(-32);
    acc_clr = 1'b0;
    check("clr_acc", acc, 0);
    check("clr_count", count, 1);
    check("clr_rd_data", bus.rd_data, -32);

    // Negative saturation
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) push_good(-32);
    check("sat_acc_neg", acc, -512);
    tick();
    bus.rd_ready = 1'b0;
    check("neg_drain", count, 0);

    // Flush of an empty FIFO lasts one cycle
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("eflush_busy", flush_busy, 1);
    tick();
    check("eflush_done", flush_busy, 0);

    // Flush with 4 entries; good samples during the window are dropped
    do_reset();
    for (int i = 1; i <= 4; i++) push_good(i);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_busy0", flush_busy, 1);
    check("fl_count0", count, 4);
    bus.rd_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.leds     = '0;
    bus.out      = 6'd9;
    for (int i = 1; i <= 4; i++) begin
      check("fl_rd_data", bus.rd_data, i);
      tick();
      check("fl_busy", flush_busy, (i < 4) ? 1 : 0);
    end
    check("fl_count", count, 0);
    check("fl_drop", drop_cnt, 4);
    bus.in_valid = 1'b0;
    bus.rd_ready = 1'b0;

    // Reset in the middle of a flush overrides all other inputs
    for (int i = 1; i <= 4; i++) push_good(i);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.rd_ready = 1'b1;
    tick();
    check("mid_busy", flush_busy, 1);
    check("mid_count", count, 3);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.leds     = '0;
    bus.out      = 6'd3;
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.rd_ready = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", bus.rd_valid, 0);
    check("mid_rst_data", bus.rd_data, 0);
    check("mid_rst_acc", acc, 0);
    check("mid_rst_err", err_cnt, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_busy", flush_busy, 0);
    // Back in RUN: a good sample is stored again
    push_good(-7);
    check("mid_run_count", count, 1);
    check("mid_run_data", bus.rd_data, -7);
    check("mid_run_acc", acc, -7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
